// File: rtl/traffic_countdown_pkg.sv
// Shared definitions for the traffic-light countdown block and the 7-segment
// display block: FSM state encodings, lamp codes, count width and display range.
package traffic_countdown_pkg;

  // Light-sequence phases; encodings are shared with the display block.
  typedef enum logic [1:0] {
    MG = 2'd0,  // main green, country red
    MY = 2'd1,  // main yellow, country red
    CG = 2'd2,  // main red, country green
    CY = 2'd3   // main red, country yellow
  } state_t;

  // Lamp codes, {R,Y,G}, active-high.
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Largest value either countdown can show; the display decodes 0..MAX_COUNT.
  localparam int MAX_COUNT = 30;
  localparam int CNT_W     = 5;

  typedef struct packed {
    logic [2:0] main_lamp;
    logic [2:0] country_lamp;
  } lamps_t;

  // Lamp pattern shown for each phase.
  function automatic lamps_t state_lamps(input state_t s);
    case (s)
      MG:      return '{main_lamp: L_GRN, country_lamp: L_RED};
      MY:      return '{main_lamp: L_YEL, country_lamp: L_RED};
      CG:      return '{main_lamp: L_RED, country_lamp: L_GRN};
      default: return '{main_lamp: L_RED, country_lamp: L_YEL};
    endcase
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler and blink-phase generator.
// Ports:
//   CLK        in   system clock
//   RET        in   asynchronous active-low reset
//   clr        in   synchronous clear: restart the second from prescaler value 0
//   tick       out  high during the last CLK cycle of each second
//   phase      out  registered blink phase, 1 in the first half of each second
//   phase_next out  value phase takes at the next edge, so the owner can
//                   register lamps that must track phase in the same cycle
module sec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RET,
  input  logic clr,
  output logic tick,
  output logic phase,
  output logic phase_next
);

  localparam int W = $clog2(TICK_DIV);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    tick     = (cnt == W'(TICK_DIV - 1));
    cnt_next = cnt + 1'b1;
    if (clr || tick) cnt_next = '0;
    phase_next = (cnt_next < W'(TICK_DIV / 2));
  end

  // NOTE: flops use non-blocking assignments with the asynchronous reset in the
  // sensitivity list; blocking here would create ordering races between blocks.
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/traffic_countdown.sv
// Traffic-light sequencer with per-road seconds-remaining counts for the
// 7-segment display, a half-second blink phase and a night-flash override.
// Ports:
//   CLK            in   system clock
//   RET            in   asynchronous active-low reset
//   NIGHT          in   asynchronous switch, 1 = night-flash mode
//   MainNumber     out  main-road seconds remaining, 0..30 (0 only at night)
//   CountryNumber  out  country-road seconds remaining, 0..30 (0 only at night)
//   C              out  blink phase, 1 in the first half of each second
//   MainLight      out  main-road lamps {R,Y,G}
//   CountryLight   out  country-road lamps {R,Y,G}
module traffic_countdown
  import traffic_countdown_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5
) (
  input  logic             CLK,
  input  logic             RET,
  input  logic             NIGHT,
  output logic [CNT_W-1:0] MainNumber,
  output logic [CNT_W-1:0] CountryNumber,
  output logic             C,
  output logic [2:0]       MainLight,
  output logic [2:0]       CountryLight
);

  if (TICK_DIV < 2 || (TICK_DIV % 2) != 0) begin : g_bad_div
    $error("TICK_DIV must be even and at least 2");
  end
  if (GREEN_T < 1 || YELLOW_T < 1 || GREEN_T + YELLOW_T > MAX_COUNT) begin : g_bad_times
    $error("GREEN_T and YELLOW_T must be >= 1 with a sum of at most MAX_COUNT");
  end

  localparam logic [CNT_W-1:0] GREEN_CNT = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YEL_CNT   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] RED_CNT   = CNT_W'(GREEN_T + YELLOW_T);

  state_t state;
  logic   night_meta;
  logic   nsync;
  logic   nsync_q;
  logic   night_exit;
  logic   tick;
  logic   phase_next;

  // Leaving night mode restarts the sequence and the current second together.
  assign night_exit = nsync_q & ~nsync;

  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK        (CLK),
    .RET        (RET),
    .clr        (night_exit),
    .tick       (tick),
    .phase      (C),
    .phase_next (phase_next)
  );

  // Two-flop synchronizer for the switch, plus one delayed copy for edge detect.
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      night_meta <= 1'b0;
      nsync      <= 1'b0;
      nsync_q    <= 1'b0;
    end else begin
      night_meta <= NIGHT;
      nsync      <= night_meta;
      nsync_q    <= nsync;
    end
  end

  // Light FSM and countdown registers. Night mode has priority over a tick in
  // the same cycle, so the sequence never advances while flashing.
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      state         <= MG;
      MainNumber    <= GREEN_CNT;
      CountryNumber <= RED_CNT;
      MainLight     <= L_GRN;
      CountryLight  <= L_RED;
    end else if (nsync) begin
      MainNumber    <= '0;
      CountryNumber <= '0;
      // Lamps use the upcoming phase so they stay aligned with the C register.
      MainLight     <= {1'b0, phase_next, 1'b0};
      CountryLight  <= {1'b0, phase_next, 1'b0};
    end else if (night_exit) begin
      state         <= MG;
      MainNumber    <= GREEN_CNT;
      CountryNumber <= RED_CNT;
      MainLight     <= L_GRN;
      CountryLight  <= L_RED;
    end else if (tick) begin
      MainNumber    <= MainNumber - 1'b1;
      CountryNumber <= CountryNumber - 1'b1;
      case (state)
        MG: if (MainNumber == 1) begin
          state        <= MY;
          MainNumber   <= YEL_CNT;
          MainLight    <= state_lamps(MY).main_lamp;
          CountryLight <= state_lamps(MY).country_lamp;
        end
        MY: if (MainNumber == 1) begin
          state         <= CG;
          MainNumber    <= RED_CNT;
          CountryNumber <= GREEN_CNT;
          MainLight     <= state_lamps(CG).main_lamp;
          CountryLight  <= state_lamps(CG).country_lamp;
        end
        CG: if (CountryNumber == 1) begin
          state         <= CY;
          CountryNumber <= YEL_CNT;
          MainLight     <= state_lamps(CY).main_lamp;
          CountryLight  <= state_lamps(CY).country_lamp;
        end
        default: if (CountryNumber == 1) begin
          state         <= MG;
          MainNumber    <= GREEN_CNT;
          CountryNumber <= RED_CNT;
          MainLight     <= state_lamps(MG).main_lamp;
          CountryLight  <= state_lamps(MG).country_lamp;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Outside night mode the red road's count and the active count both reload
  // on the tick they would reach zero, so a zero here means a broken sequence.
  a_no_zero: assert property (@(posedge CLK) disable iff (!RET)
    !nsync_q |-> (MainNumber != '0 && CountryNumber != '0))
    else $error("countdown reached zero outside night mode");
`endif

endmodule

// File: tb/tb_traffic_countdown.sv
module tb_traffic_countdown;
  import traffic_countdown_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int GREEN_T  = 25;
  localparam int YELLOW_T = 5;

  logic       CLK = 1'b0;
  logic       RET = 1'b0;
  logic       NIGHT = 1'b0;
  logic [4:0] MainNumber;
  logic [4:0] CountryNumber;
  logic       C;
  logic [2:0] MainLight;
  logic [2:0] CountryLight;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  bit mon_zero  = 1'b0;
  int zero_seen = 0;

  always #5 CLK = ~CLK;

  traffic_countdown #(
    .TICK_DIV (TICK_DIV),
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T)
  ) dut (
    .CLK           (CLK),
    .RET           (RET),
    .NIGHT         (NIGHT),
    .MainNumber    (MainNumber),
    .CountryNumber (CountryNumber),
    .C             (C),
    .MainLight     (MainLight),
    .CountryLight  (CountryLight)
  );

  typedef struct {
    int         at;   // CLK cycles since reset release
    logic [4:0] main_n;
    logic [4:0] country_n;
    logic [2:0] main_l;
    logic [2:0] country_l;
    logic       c;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [4:0] m, input logic [4:0] c_n,
                            input logic [2:0] ml, input logic [2:0] cl, input logic ph);
    check({name, ".main"},    32'(MainNumber),    32'(m));
    check({name, ".country"}, 32'(CountryNumber), 32'(c_n));
    check({name, ".mlight"},  32'(MainLight),     32'(ml));
    check({name, ".clight"},  32'(CountryLight),  32'(cl));
    check({name, ".c"},       32'(C),             32'(ph));
  endtask

  // Advance n clock edges, sampling on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (mon_zero && (MainNumber == 0 || CountryNumber == 0)) zero_seen++;
    end
  endtask

  initial begin
    // Hand-computed: tick fires on every 4th edge after release, C = (cycle % 4) < 2.
    vecs[0]  = '{0,   25, 30, L_GRN, L_RED, 1'b1};
    vecs[1]  = '{1,   25, 30, L_GRN, L_RED, 1'b1};
    vecs[2]  = '{2,   25, 30, L_GRN, L_RED, 1'b0};
    vecs[3]  = '{3,   25, 30, L_GRN, L_RED, 1'b0};
    vecs[4]  = '{4,   24, 29, L_GRN, L_RED, 1'b1};
    vecs[5]  = '{6,   24, 29, L_GRN, L_RED, 1'b0};
    vecs[6]  = '{96,   1,  6, L_GRN, L_RED, 1'b1};
    vecs[7]  = '{99,   1,  6, L_GRN, L_RED, 1'b0};
    vecs[8]  = '{100,  5,  5, L_YEL, L_RED, 1'b1};
    vecs[9]  = '{116,  1,  1, L_YEL, L_RED, 1'b1};
    vecs[10] = '{120, 30, 25, L_RED, L_GRN, 1'b1};
    vecs[11] = '{216,  6,  1, L_RED, L_GRN, 1'b1};
    vecs[12] = '{220,  5,  5, L_RED, L_YEL, 1'b1};
    vecs[13] = '{236,  1,  1, L_RED, L_YEL, 1'b1};
    vecs[14] = '{240, 25, 30, L_GRN, L_RED, 1'b1};
    vecs[15] = '{244, 24, 29, L_GRN, L_RED, 1'b1};
    vecs[16] = '{380, 25, 20, L_RED, L_GRN, 1'b1};

    // Held in reset.
    @(negedge CLK);
    @(negedge CLK);
    check_outs("reset_hold", 25, 30, L_GRN, L_RED, 1'b1);
    RET = 1'b1;
    cyc = 0;

    // Full sequence, with a zero monitor across the whole normal-mode run.
    mon_zero = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].at - cyc);
      check_outs($sformatf("seq_c%0d", vecs[i].at), vecs[i].main_n, vecs[i].country_n,
                 vecs[i].main_l, vecs[i].country_l, vecs[i].c);
    end
    mon_zero = 1'b0;
    check("no_zero_normal", 32'(zero_seen), 32'd0);

    // Night mode entered mid-CG: outputs change 3 edges after the pin.
    NIGHT = 1'b1;
    step(2);
    check_outs("night_lat2", 25, 20, L_RED, L_GRN, 1'b0);
    step(1);
    check_outs("night_on_c383", 0, 0, 3'b000, 3'b000, 1'b0);
    step(1);
    check_outs("night_on_c384", 0, 0, L_YEL, L_YEL, 1'b1);
    step(36);
    check_outs("night_c420", 0, 0, L_YEL, L_YEL, 1'b1);
    NIGHT = 1'b0;
    step(2);
    check_outs("night_exit_lat2", 0, 0, 3'b000, 3'b000, 1'b0);
    step(1);
    check_outs("night_exit", 25, 30, L_GRN, L_RED, 1'b1);
    step(3);
    check_outs("exit_pre_tick", 25, 30, L_GRN, L_RED, 1'b0);
    step(1);
    check_outs("exit_first_tick", 24, 29, L_GRN, L_RED, 1'b1);

    // Reset pulse mid-MY (26 ticks after the restart).
    step(100);
    check_outs("mid_my", 4, 4, L_YEL, L_RED, 1'b1);
    RET = 1'b0;
    #1;
    check_outs("async_reset", 25, 30, L_GRN, L_RED, 1'b1);
    @(negedge CLK);
    RET = 1'b1;
    cyc = 0;
    check_outs("reset_release", 25, 30, L_GRN, L_RED, 1'b1);
    step(3);
    check_outs("rst_pre_tick", 25, 30, L_GRN, L_RED, 1'b0);
    step(1);
    check_outs("rst_first_tick", 24, 29, L_GRN, L_RED, 1'b1);

    // Night raised so the synchronized level first appears in a tick cycle.
    step(1);
    NIGHT = 1'b1;
    step(2);
    check_outs("tick_night_pre", 24, 29, L_GRN, L_RED, 1'b0);
    step(1);
    check_outs("tick_night_win", 0, 0, L_YEL, L_YEL, 1'b1);
    step(1);
    check_outs("tick_night_hold", 0, 0, L_YEL, L_YEL, 1'b1);
    NIGHT = 1'b0;
    step(3);
    check_outs("tick_night_exit", 25, 30, L_GRN, L_RED, 1'b1);
    step(4);
    check_outs("tick_night_resume", 24, 29, L_GRN, L_RED, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
